// File: rtl/xmtr.sv
// ---------------------------------------------------------------------------
// xmtr : serial framing transmitter
//
// Host bytes are queued in a small FIFO.  Each byte leaves on the one-bit
// line as a 16-bit frame, MSB first: the MATCH header byte, then the data
// byte.  Between frames the line holds IDLE_BIT.  If another byte is
// already queued when a frame ends, the next frame starts on that same
// edge, so frames run back to back with no gap.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   data_in    in   [7:0] byte to queue
//   write      in   push data_in this cycle (dropped if the FIFO is full)
//   clear_err  in   clear the sticky overflow flag
//   full       out  FIFO holds DEPTH entries (registered)
//   empty      out  FIFO holds no entries (registered)
//   busy       out  a frame is on the line (state != IDLE)
//   overflow   out  sticky: a write arrived while full
//   data_out   out  serial line (registered)
//   dbg_state  out  [1:0] current FSM state (0 idle, 1 head, 2 body)
//
// Handshake: there is no ready signal.  A write is taken on any clock edge
// where write is high and the registered full flag is low; otherwise the
// byte is discarded and overflow is set.
// ---------------------------------------------------------------------------
module xmtr #(
   parameter logic [7:0] MATCH    = 8'hA5,
   parameter int         DEPTH    = 4,
   parameter logic       IDLE_BIT = ~MATCH[7]
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       write,
   input  logic       clear_err,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       overflow,
   output logic       data_out,
   output logic [1:0] dbg_state
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HEAD = 2'd1,
      S_BODY = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [15:0]     frame_q, frame_d;
   logic            dout_q, dout_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic            ovf_q, ovf_d;

   logic [7:0]      mem [DEPTH];
   logic            push;
   logic            pop;

   // Full is the registered flag, so a write in the same cycle as a pop
   // from a full FIFO is still dropped.
   assign push = write && !full_q;

   // ---------------- FSM: next state, frame shifter, line bit ----------------
   always_comb begin
      pop     = 1'b0;
      state_d = state_q;
      cnt_d   = cnt_q;
      frame_d = frame_q;
      dout_d  = dout_q;

      case (state_q)
         S_IDLE: begin
            dout_d = IDLE_BIT;
            if (!empty_q) begin
               pop     = 1'b1;
               frame_d = {MATCH, mem[rd_ptr_q]};
               dout_d  = MATCH[7];
               cnt_d   = 4'd0;
               state_d = S_HEAD;
            end
         end

         S_HEAD, S_BODY: begin
            // data_out already shows frame_q[15]; shift and present the
            // next bit.  cnt==k on this edge means bit (14-k) goes out.
            cnt_d   = cnt_q + 4'd1;
            frame_d = {frame_q[14:0], 1'b0};
            dout_d  = frame_q[14];
            if (state_q == S_HEAD && cnt_q == 4'd7) begin
               state_d = S_BODY;
            end
            if (cnt_q == 4'd15) begin
               if (!empty_q) begin
                  // Chain straight into the next frame, no idle bit.
                  pop     = 1'b1;
                  frame_d = {MATCH, mem[rd_ptr_q]};
                  dout_d  = MATCH[7];
                  cnt_d   = 4'd0;
                  state_d = S_HEAD;
               end else begin
                  dout_d  = IDLE_BIT;
                  cnt_d   = 4'd0;
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            dout_d  = IDLE_BIT;
            cnt_d   = 4'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------- FIFO bookkeeping ----------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      full_d  = (count_d == (AW + 1)'(DEPTH));
      empty_d = (count_d == '0);
   end

   // Set has priority over clear.
   always_comb begin
      ovf_d = ovf_q;
      if (write && full_q) begin
         ovf_d = 1'b1;
      end else if (clear_err) begin
         ovf_d = 1'b0;
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         frame_q  <= 16'd0;
         dout_q   <= IDLE_BIT;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         frame_q  <= frame_d;
         dout_q   <= dout_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   assign full      = full_q;
   assign empty     = empty_q;
   assign busy      = (state_q != S_IDLE);
   assign overflow  = ovf_q;
   assign data_out  = dout_q;
   assign dbg_state = state_q;

endmodule
